// File: rtl/game_score_counter_if.sv
// Control pulses in, BCD score/time digits and round status out.
// Latency: signal bundle only, no logic.
// Backpressure: none; the counter accepts a pulse on every cycle.
interface game_score_counter_if;
    logic       start;
    logic       hit;
    logic       penalty;
    logic       clear;
    logic [3:0] scoreOnes;
    logic [3:0] scoreTens;
    logic [3:0] timeOnes;
    logic [3:0] timeTens;
    logic       playing;
    logic       gameOver;
    logic       done;

    // Stimulus side: drives the event pulses, observes the counter.
    modport master (
        output start, hit, penalty, clear,
        input  scoreOnes, scoreTens, timeOnes, timeTens, playing, gameOver, done
    );

    // Counter side.
    modport slave (
        input  start, hit, penalty, clear,
        output scoreOnes, scoreTens, timeOnes, timeTens, playing, gameOver, done
    );
endinterface

// File: rtl/game_score_counter.sv
// Round timer plus two-digit BCD score; freezes score and flags game-over at round end.
// Latency: every input pulse is reflected on the outputs one clock after the edge that samples it.
// Backpressure: none; pulses are consumed every cycle, ignored ones are simply dropped.
module game_score_counter #(
    parameter int TICK_DIV   = 50000000,
    parameter int ROUND_TENS = 3,
    parameter int ROUND_ONES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    game_score_counter_if.slave   bus
);
    // Smallest width that still holds TICK_DIV-1.
    localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]    RL_TENS = 4'(ROUND_TENS);
    localparam logic [3:0]    RL_ONES = 4'(ROUND_ONES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t        state;
    state_t        nextState;
    logic [PW-1:0] prescaler;
    logic [3:0]    sOnes;
    logic [3:0]    sTens;
    logic [3:0]    tOnes;
    logic [3:0]    tTens;
    logic          doneR;

    logic          tick;
    logic          finalTick;
    logic          reload;
    logic [3:0]    nsOnes;
    logic [3:0]    nsTens;

    // Round events: timer tick, last tick of the round, and a fresh-round reload.
    always_comb begin
        tick      = (state == PLAY) && (prescaler == PRE_MAX);
        finalTick = tick && (tTens == 4'd0) && (tOnes == 4'd1);
        reload    = bus.start && ((state == IDLE) || (state == OVER));
    end

    // Next BCD score from hit/penalty; simultaneous pulses cancel, both ends saturate.
    always_comb begin
        nsOnes = sOnes;
        nsTens = sTens;
        if (bus.hit && !bus.penalty) begin
            if (!((sTens == 4'd9) && (sOnes == 4'd9))) begin
                if (sOnes == 4'd9) begin
                    nsOnes = 4'd0;
                    nsTens = sTens + 4'd1;
                end else begin
                    nsOnes = sOnes + 4'd1;
                end
            end
        end else if (bus.penalty && !bus.hit) begin
            if (!((sTens == 4'd0) && (sOnes == 4'd0))) begin
                if (sOnes == 4'd0) begin
                    nsOnes = 4'd9;
                    nsTens = sTens - 4'd1;
                end else begin
                    nsOnes = sOnes - 4'd1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: start opens a round from IDLE/OVER (start beats clear), last tick ends it.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (bus.start) nextState = PLAY;
            PLAY: if (finalTick) nextState = OVER;
            OVER: begin
                if (bus.start) begin
                    nextState = PLAY;
                end else if (bus.clear) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Score, timer, prescaler and done pulse; only PLAY lets them move, except the reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            sOnes     <= 4'd0;
            sTens     <= 4'd0;
            tOnes     <= 4'd0;
            tTens     <= 4'd0;
            doneR     <= 1'b0;
        end else begin
            doneR <= finalTick;
            if (reload) begin
                prescaler <= '0;
                sOnes     <= 4'd0;
                sTens     <= 4'd0;
                tOnes     <= RL_ONES;
                tTens     <= RL_TENS;
            end else if (state == PLAY) begin
                sOnes <= nsOnes;
                sTens <= nsTens;
                if (tick) begin
                    prescaler <= '0;
                    if (tOnes == 4'd0) begin
                        tOnes <= 4'd9;
                        tTens <= tTens - 4'd1;
                    end else begin
                        tOnes <= tOnes - 4'd1;
                    end
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

    // Status flags decode straight from the state register.
    always_comb begin
        bus.playing  = (state == PLAY);
        bus.gameOver = (state == OVER);
    end

    assign bus.scoreOnes = sOnes;
    assign bus.scoreTens = sTens;
    assign bus.timeOnes  = tOnes;
    assign bus.timeTens  = tTens;
    assign bus.done      = doneR;
endmodule
